rv32m_issue: RTL and testbench

- Issue/sequencing stage directly upstream of the rv32m_extension multiply/divide unit.
- Accepts decoded R-type instructions with operand values from decode via valid/ready, and verifies they are RV32M ops.
- Drives the unit and waits its fixed latency, or resolves the RISC-V divide special cases locally.
- Returns the result with its destination register to writeback via valid/ready.

---
 rtl/rv32m_issue.sv | 146 ++++++++++++++
 tb/tb_rv32m_issue.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv32m_issue.sv
// Issue/sequencing stage in front of the RV32M multiply/divide unit.
// Optional macro RV32M_ZERO_SKIP_EN resolves multiplies by zero locally.
module rv32m_issue #(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_rs2_val,
    output logic [31:0] m_instr,
    output logic [31:0] m_op1,
    output logic [31:0] m_op2,
    input  logic [31:0] m_result,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        illegal,
    output logic        busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state;
    logic [31:0]      instr_q, op1_q, op2_q;
    logic [CNT_W-1:0] cnt;

    logic        accept, is_m, spec;
    logic [31:0] spec_res;
    logic        ovf;

    assign accept   = in_valid & in_ready;
    assign is_m     = (in_instr[6:0] == 7'b0110011) && (in_instr[31:25] == 7'b0000001);
    assign ovf      = (in_rs1_val == 32'h8000_0000) && (in_rs2_val == 32'hFFFF_FFFF);
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign wb_valid = (state == DONE);

    // The unit only sees a live opcode while an op is in flight; otherwise it holds.
    assign m_instr = (state == ISSUE || state == WAIT) ? instr_q : 32'd0;
    assign m_op1   = (state == ISSUE || state == WAIT) ? op1_q   : 32'd0;
    assign m_op2   = (state == ISSUE || state == WAIT) ? op2_q   : 32'd0;

    always_comb begin
        spec     = 1'b0;
        spec_res = 32'd0;
        case (in_instr[14:12])
            3'b100: begin
                if (in_rs2_val == 32'd0) begin
                    spec     = 1'b1;
                    spec_res = 32'hFFFF_FFFF;
                end else if (ovf) begin
                    spec     = 1'b1;
                    spec_res = 32'h8000_0000;
                end
            end
            3'b101: begin
                if (in_rs2_val == 32'd0) begin
                    spec     = 1'b1;
                    spec_res = 32'hFFFF_FFFF;
                end
            end
            3'b110: begin
                if (in_rs2_val == 32'd0) begin
                    spec     = 1'b1;
                    spec_res = in_rs1_val;
                end else if (ovf) begin
                    spec     = 1'b1;
                    spec_res = 32'd0;
                end
            end
            3'b111: begin
                if (in_rs2_val == 32'd0) begin
                    spec     = 1'b1;
                    spec_res = in_rs1_val;
                end
            end
            default: begin
`ifdef RV32M_ZERO_SKIP_EN
                if (in_rs1_val == 32'd0 || in_rs2_val == 32'd0) begin
                    spec     = 1'b1;
                    spec_res = 32'd0;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            instr_q <= 32'd0;
            op1_q   <= 32'd0;
            op2_q   <= 32'd0;
            cnt     <= '0;
            wb_rd   <= 5'd0;
            wb_data <= 32'd0;
            illegal <= 1'b0;
        end else begin
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!is_m) begin
                            illegal <= 1'b1;
                        end else begin
                            instr_q <= in_instr;
                            op1_q   <= in_rs1_val;
                            op2_q   <= in_rs2_val;
                            wb_rd   <= in_instr[11:7];
                            if (spec) begin
                                wb_data <= spec_res;
                                // Writes to x0 are never presented to writeback.
                                state   <= (in_instr[11:7] == 5'd0) ? IDLE : DONE;
                            end else begin
                                state   <= ISSUE;
                            end
                        end
                    end
                end
                ISSUE: begin
                    cnt   <= CNT_W'(LATENCY);
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        wb_data <= m_result;
                        state   <= (wb_rd == 5'd0) ? IDLE : DONE;
                    end
                end
                default: begin
                    if (wb_ready) state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32m_issue.sv
// Directed bench for rv32m_issue with a one-cycle behavioural M unit.
module tb_rv32m_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'd0;
    logic [31:0] in_rs1_val = 32'd0;
    logic [31:0] in_rs2_val = 32'd0;
    logic [31:0] m_instr, m_op1, m_op2;
    logic [31:0] m_result = 32'd0;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    rv32m_issue dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .m_instr(m_instr), .m_op1(m_op1), .m_op2(m_op2), .m_result(m_result),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] unit_calc(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] pu;
        logic signed [63:0] ps;
        pu = {32'd0, a} * {32'd0, b};
        ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        case (f3)
            3'b000:  return pu[31:0];
            3'b001:  return ps[63:32];
            3'b011:  return pu[63:32];
            3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b111:  return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    // One-cycle M unit: registers a result only while it sees an M opcode.
    always @(posedge clk)
        if (m_instr[6:0] == 7'b0110011)
            m_result <= unit_calc(m_instr[14:12], m_op1, m_op2);

    function automatic logic [31:0] rtype(input logic [2:0] f3, input logic [4:0] rd);
        return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    task automatic offer(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        in_valid   = 1'b1;
        in_instr   = ins;
        in_rs1_val = a;
        in_rs2_val = b;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_instr   = 32'd0;
    endtask

    task automatic test_reset;
        #2;
        n_chk++; if (wb_valid !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0) begin
            n_fail++; $display("FAIL reset_wb: valid=%b rd=%0d data=%h, want 0/0/0", wb_valid, wb_rd, wb_data); end
        n_chk++; if (m_instr !== 32'd0 || m_op1 !== 32'd0 || m_op2 !== 32'd0 || illegal !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_m: m_instr=%h op1=%h op2=%h illegal=%b busy=%b, want all 0", m_instr, m_op1, m_op2, illegal, busy); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_mul;
        int active = 0;
        wb_ready = 1'b1;
        offer(rtype(3'b000, 5'd5), 32'd7, 32'd6);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (m_instr !== 32'd0) active++;
            if (k < 3) begin
                n_chk++; if (wb_valid !== 1'b0) begin
                    n_fail++; $display("FAIL mul_early_valid: cycle %0d wb_valid=%b want 0", k, wb_valid); end
            end else if (k == 3) begin
                n_chk++; if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'd42) begin
                    n_fail++; $display("FAIL mul_result: valid=%b rd=%0d data=%0d want 1/5/42", wb_valid, wb_rd, wb_data); end
            end else begin
                n_chk++; if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
                    n_fail++; $display("FAIL mul_release: valid=%b in_ready=%b want 0/1", wb_valid, in_ready); end
            end
        end
        n_chk++; if (active != 2) begin
            n_fail++; $display("FAIL mul_issue_cycles: m_instr live %0d cycles want 2", active); end
    endtask

    task automatic test_div_zero;
        logic [2:0]  f3s [2] = '{3'b101, 3'b111};
        logic [31:0] exp [2] = '{32'hFFFF_FFFF, 32'd100};
        for (int i = 0; i < 2; i++) begin
            offer(rtype(f3s[i], 5'd3), 32'd100, 32'd0);
            @(negedge clk);
            n_chk++; if (wb_valid !== 1'b1 || wb_rd !== 5'd3 || wb_data !== exp[i] || m_instr !== 32'd0) begin
                n_fail++; $display("FAIL divzero_%0d: valid=%b rd=%0d data=%h m_instr=%h want 1/3/%h/0",
                                   i, wb_valid, wb_rd, wb_data, m_instr, exp[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_overflow;
        logic [2:0]  f3s [2] = '{3'b100, 3'b110};
        logic [31:0] exp [2] = '{32'h8000_0000, 32'd0};
        for (int i = 0; i < 2; i++) begin
            offer(rtype(f3s[i], 5'd4), 32'h8000_0000, 32'hFFFF_FFFF);
            @(negedge clk);
            n_chk++; if (wb_valid !== 1'b1 || wb_data !== exp[i] || m_instr !== 32'd0) begin
                n_fail++; $display("FAIL overflow_%0d: valid=%b data=%h m_instr=%h want 1/%h/0",
                                   i, wb_valid, wb_data, m_instr, exp[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure;
        wb_ready = 1'b0;
        offer(rtype(3'b000, 5'd7), 32'd3, 32'd4);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            n_chk++; if (wb_valid !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 32'd12 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL stall_%0d: valid=%b rd=%0d data=%0d in_ready=%b want 1/7/12/0",
                                   k, wb_valid, wb_rd, wb_data, in_ready); end
            @(negedge clk);
        end
        wb_ready = 1'b1;
        @(negedge clk);
        n_chk++; if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL stall_release: valid=%b in_ready=%b want 0/1", wb_valid, in_ready); end
    endtask

    task automatic test_illegal_and_x0;
        int seen = 0;
        offer(32'h0020_8033, 32'd1, 32'd2);
        @(negedge clk);
        n_chk++; if (illegal !== 1'b1 || busy !== 1'b0 || wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL illegal_pulse: illegal=%b busy=%b valid=%b want 1/0/0", illegal, busy, wb_valid); end
        @(negedge clk);
        n_chk++; if (illegal !== 1'b0) begin
            n_fail++; $display("FAIL illegal_width: illegal=%b want 0", illegal); end
        offer(rtype(3'b000, 5'd0), 32'd2, 32'd3);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (wb_valid !== 1'b0) seen++;
            if (k == 1) begin
                n_chk++; if (busy !== 1'b1) begin
                    n_fail++; $display("FAIL x0_busy: busy=%b want 1", busy); end
            end
            if (k == 3) begin
                n_chk++; if (busy !== 1'b0) begin
                    n_fail++; $display("FAIL x0_idle: busy=%b want 0", busy); end
            end
        end
        n_chk++; if (seen != 0) begin
            n_fail++; $display("FAIL x0_wb: wb_valid seen %0d cycles want 0", seen); end
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        offer(rtype(3'b011, 5'd9), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (busy !== 1'b1 || m_instr === 32'd0) begin
            n_fail++; $display("FAIL midrst_wait: busy=%b m_instr=%h want busy 1 and live op", busy, m_instr); end
        rst = 1'b0;
        #1;
        n_chk++; if (busy !== 1'b0 || m_instr !== 32'd0 || wb_valid !== 1'b0 || wb_data !== 32'd0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst_outputs: busy=%b m_instr=%h valid=%b data=%h in_ready=%b want 0/0/0/0/1",
                               busy, m_instr, wb_valid, wb_data, in_ready); end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (wb_valid !== 1'b0) seen++;
        end
        n_chk++; if (seen != 0) begin
            n_fail++; $display("FAIL midrst_wb: wb_valid seen %0d cycles want 0", seen); end
    endtask

    task automatic test_zero_mul;
        offer(rtype(3'b000, 5'd6), 32'd5, 32'd0);
`ifdef RV32M_ZERO_SKIP_EN
        @(negedge clk);
        n_chk++; if (wb_valid !== 1'b1 || wb_data !== 32'd0 || m_instr !== 32'd0) begin
            n_fail++; $display("FAIL zero_skip: valid=%b data=%h m_instr=%h want 1/0/0", wb_valid, wb_data, m_instr); end
`else
        @(negedge clk);
        n_chk++; if (wb_valid !== 1'b0 || m_instr === 32'd0) begin
            n_fail++; $display("FAIL zero_issue: valid=%b m_instr=%h want 0 and live op", wb_valid, m_instr); end
        repeat (2) @(negedge clk);
        n_chk++; if (wb_valid !== 1'b1 || wb_rd !== 5'd6 || wb_data !== 32'd0) begin
            n_fail++; $display("FAIL zero_result: valid=%b rd=%0d data=%h want 1/6/0", wb_valid, wb_rd, wb_data); end
`endif
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_mul;
        test_div_zero;
        test_overflow;
        test_backpressure;
        test_illegal_and_x0;
        test_reset_mid;
        test_zero_mul;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
